// File: rtl/ad9648_spi_shifter.sv
// ad9648_spi_shifter
//   Serial engine of the AD9648 3-wire SPI configuration path. A start pulse
//   (coincident with CSB assertion) loads a 24-bit frame
//   {R/W, W1:W0 = 00, 13-bit address, 8-bit data}. The frame is shifted out
//   MSB first on SDIO with SCLK idling low. On reads, SDIO is released after
//   the 16-bit instruction and the readback byte is captured. A one-cycle stop
//   pulse at the end lets the chip-select stage deassert CSB.
//
// Ports
//   clk_i          system clock
//   rst_clk_ni     asynchronous active-low reset
//   start_gen_i    one-cycle frame start (accepted only when idle)
//   rw_i           1 = read, 0 = write; sampled with start_gen_i
//   addr_i         register address; sampled with start_gen_i
//   wdata_i        write byte; sampled with start_gen_i
//   busy_o         frame in progress
//   sclk_o         SPI clock, idles low
//   sdio_o         serial data out
//   sdio_oe_o      SDIO output enable for the IOBUF
//   sdio_i         serial data in
//   stop_gen_o     one-cycle end-of-frame pulse
//   rdata_o        last readback byte, held until the next read completes
//   rdata_valid_o  one-cycle pulse with stop_gen_o on reads only
module ad9648_spi_shifter #(
    parameter int CLK_DIV = 4,
    parameter int ADDR_W  = 13,
    parameter int DATA_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_clk_ni,
    input  logic              start_gen_i,
    input  logic              rw_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              busy_o,
    output logic              sclk_o,
    output logic              sdio_o,
    output logic              sdio_oe_o,
    input  logic              sdio_i,
    output logic              stop_gen_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rdata_valid_o
);

    localparam int FRAME_W = 3 + ADDR_W + DATA_W;
    localparam logic [7:0] DIV_M1   = 8'(CLK_DIV - 1);
    localparam logic [4:0] LAST_BIT = 5'(FRAME_W);
    // Number of instruction bits; readback starts on the following rise.
    localparam logic [4:0] INSTR_N  = 5'(FRAME_W - DATA_W);

    typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} state_t;

    state_t             state;
    logic [7:0]         hp_cnt;
    logic [4:0]         bit_cnt;
    logic [FRAME_W-1:0] tx_sh;
    logic [DATA_W-1:0]  rx_sh;
    logic               rw_q;
    logic               hp_tc;

    assign hp_tc  = (hp_cnt == DIV_M1);
    // MSB of the shift register drives the line directly, so the first bit
    // is present from the start edge and advances on each SCLK fall.
    assign sdio_o = tx_sh[FRAME_W-1];

    always_ff @(posedge clk_i or negedge rst_clk_ni) begin
        if (!rst_clk_ni) begin
            state         <= IDLE;
            hp_cnt        <= '0;
            bit_cnt       <= '0;
            tx_sh         <= '0;
            rx_sh         <= '0;
            rw_q          <= 1'b0;
            busy_o        <= 1'b0;
            sclk_o        <= 1'b0;
            sdio_oe_o     <= 1'b0;
            stop_gen_o    <= 1'b0;
            rdata_o       <= '0;
            rdata_valid_o <= 1'b0;
        end else begin
            stop_gen_o    <= 1'b0;
            rdata_valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_gen_i) begin
                        tx_sh     <= {rw_i, 2'b00, addr_i, wdata_i};
                        rw_q      <= rw_i;
                        busy_o    <= 1'b1;
                        sdio_oe_o <= 1'b1;
                        hp_cnt    <= '0;
                        bit_cnt   <= '0;
                        state     <= LEAD;
                    end
                end
                // CSB-to-SCLK setup: one half-period with SCLK low.
                LEAD: begin
                    if (hp_tc) begin
                        hp_cnt <= '0;
                        state  <= SHIFT;
                    end else begin
                        hp_cnt <= hp_cnt + 8'd1;
                    end
                end
                SHIFT: begin
                    if (hp_tc) begin
                        hp_cnt <= '0;
                        if (!sclk_o) begin
                            // Rising edge: the readback bit is sampled here,
                            // bit_cnt still holds the number of prior rises.
                            sclk_o  <= 1'b1;
                            bit_cnt <= bit_cnt + 5'd1;
                            if (rw_q && bit_cnt >= INSTR_N)
                                rx_sh <= {rx_sh[DATA_W-2:0], sdio_i};
                        end else begin
                            sclk_o <= 1'b0;
                            tx_sh  <= {tx_sh[FRAME_W-2:0], 1'b0};
                            // Release the line right after the last
                            // instruction bit has been clocked in.
                            if (rw_q && bit_cnt == INSTR_N)
                                sdio_oe_o <= 1'b0;
                            if (bit_cnt == LAST_BIT)
                                state <= TRAIL;
                        end
                    end else begin
                        hp_cnt <= hp_cnt + 8'd1;
                    end
                end
                // Hold state through the stop cycle so a start coinciding
                // with stop_gen_o is ignored; IDLE is entered one cycle later.
                TRAIL: begin
                    if (stop_gen_o) begin
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end else if (hp_tc) begin
                        stop_gen_o <= 1'b1;
                        sdio_oe_o  <= 1'b0;
                        if (rw_q) begin
                            rdata_o       <= rx_sh;
                            rdata_valid_o <= 1'b1;
                        end
                    end else begin
                        hp_cnt <= hp_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ad9648_spi_shifter.sv
module tb_ad9648_spi_shifter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  start_v = 3'b000;
    logic        rw_r = 1'b0;
    logic [12:0] addr_r = '0;
    logic [7:0]  wdata_r = '0;
    logic        sdio_i = 1'b0;
    logic [2:0]  busy_v, sclk_v, sdio_v, oe_v, stop_v, rv_v;
    logic [7:0]  rdata2, rdata4, rdata255;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ad9648_spi_shifter #(.CLK_DIV(2)) u_div2 (
        .clk_i(clk), .rst_clk_ni(rst_n), .start_gen_i(start_v[0]), .rw_i(rw_r),
        .addr_i(addr_r), .wdata_i(wdata_r), .busy_o(busy_v[0]), .sclk_o(sclk_v[0]),
        .sdio_o(sdio_v[0]), .sdio_oe_o(oe_v[0]), .sdio_i(sdio_i),
        .stop_gen_o(stop_v[0]), .rdata_o(rdata2), .rdata_valid_o(rv_v[0]));

    ad9648_spi_shifter #(.CLK_DIV(4)) u_div4 (
        .clk_i(clk), .rst_clk_ni(rst_n), .start_gen_i(start_v[1]), .rw_i(rw_r),
        .addr_i(addr_r), .wdata_i(wdata_r), .busy_o(busy_v[1]), .sclk_o(sclk_v[1]),
        .sdio_o(sdio_v[1]), .sdio_oe_o(oe_v[1]), .sdio_i(sdio_i),
        .stop_gen_o(stop_v[1]), .rdata_o(rdata4), .rdata_valid_o(rv_v[1]));

    ad9648_spi_shifter #(.CLK_DIV(255)) u_div255 (
        .clk_i(clk), .rst_clk_ni(rst_n), .start_gen_i(start_v[2]), .rw_i(rw_r),
        .addr_i(addr_r), .wdata_i(wdata_r), .busy_o(busy_v[2]), .sclk_o(sclk_v[2]),
        .sdio_o(sdio_v[2]), .sdio_oe_o(oe_v[2]), .sdio_i(sdio_i),
        .stop_gen_o(stop_v[2]), .rdata_o(rdata255), .rdata_valid_o(rv_v[2]));

    typedef struct {
        logic        rw;
        logic [12:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rbyte;
        logic [23:0] exp_bits;
        int          exp_oe_low;
        int          exp_rv;
        logic [7:0]  exp_rdata;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Runs one frame on the CLK_DIV=4 instance; k counts clk edges after T0.
    task automatic run_frame(
        input  logic rw, input logic [12:0] addr, input logic [7:0] wdata,
        input  logic [7:0] rbyte, input bit inj, input bit chain,
        output int first_rise, output int n_rise, output logic [23:0] bits,
        output int stop_k, output int n_stop, output int busy_low_k,
        output int oe_low_k, output int n_rv, output int rv_at_stop,
        output int busy_after);
        logic prev;
        int   n_fall;
        first_rise = -1; n_rise = 0; bits = '0; stop_k = -1; n_stop = 0;
        busy_low_k = -1; oe_low_k = -1; n_rv = 0; rv_at_stop = 0;
        busy_after = 0; n_fall = 0; prev = 1'b0;
        sdio_i = 1'b1;
        @(negedge clk);
        rw_r = rw; addr_r = addr; wdata_r = wdata; start_v[1] = 1'b1;
        @(posedge clk); #1;
        start_v[1] = 1'b0;
        rw_r = ~rw; addr_r = ~addr; wdata_r = ~wdata;
        chk("t0_busy", busy_v[1], 1);
        chk("t0_oe", oe_v[1], 1);
        chk("t0_sdio", sdio_v[1], rw);
        for (int k = 1; k <= 209; k++) begin
            @(posedge clk); #1;
            if (sclk_v[1] && !prev) begin
                n_rise++;
                if (first_rise < 0) first_rise = k;
                bits = {bits[22:0], sdio_v[1]};
            end
            if (!sclk_v[1] && prev) begin
                n_fall++;
                if (rw && n_fall >= 16 && n_fall <= 23) sdio_i = rbyte[23 - n_fall];
            end
            if (stop_v[1]) begin
                n_stop++;
                if (stop_k < 0) stop_k = k;
                if (rv_v[1]) rv_at_stop = 1;
            end
            if (rv_v[1]) n_rv++;
            if (!busy_v[1] && busy_low_k < 0) busy_low_k = k;
            if (!oe_v[1] && oe_low_k < 0) oe_low_k = k;
            if (k >= 202 && busy_v[1]) busy_after = 1;
            prev = sclk_v[1];
            // Stimulus for the next edge.
            if (inj && k == 49) start_v[1] = 1'b1;
            if (inj && k == 50) start_v[1] = 1'b0;
            if (inj && stop_k > 0 && k == stop_k) start_v[1] = 1'b1;
            if (inj && stop_k > 0 && k == stop_k + 1) start_v[1] = 1'b0;
            if (chain && stop_k > 0 && k == stop_k + 1) begin
                rw_r = 1'b0; addr_r = 13'h0055; wdata_r = 8'h11; start_v[1] = 1'b1;
            end
            if (chain && stop_k > 0 && k == stop_k + 2) start_v[1] = 1'b0;
        end
        sdio_i = 1'b0;
    endtask

    task automatic run_div(input int idx, input int cd);
        logic prev;
        int   last_change, first_rise, rises, bad, stop_k;
        prev = 1'b0; last_change = 0; first_rise = -1; rises = 0; bad = 0; stop_k = -1;
        @(negedge clk);
        rw_r = 1'b0; addr_r = 13'h0123; wdata_r = 8'h5C; start_v[idx] = 1'b1;
        @(posedge clk); #1;
        start_v[idx] = 1'b0;
        for (int k = 1; k <= 50 * cd + 10; k++) begin
            @(posedge clk); #1;
            if (sclk_v[idx] != prev) begin
                if (first_rise >= 0 && (k - last_change) != cd) bad++;
                if (sclk_v[idx]) begin
                    rises++;
                    if (first_rise < 0) first_rise = k;
                end
                last_change = k;
                prev = sclk_v[idx];
            end
            if (stop_v[idx] && stop_k < 0) stop_k = k;
        end
        chk($sformatf("div%0d_first_rise", cd), first_rise, 2 * cd);
        chk($sformatf("div%0d_rises", cd), rises, 24);
        chk($sformatf("div%0d_bad_halfper", cd), bad, 0);
        chk($sformatf("div%0d_stop_time", cd), stop_k, 50 * cd);
        chk($sformatf("div%0d_busy_end", cd), busy_v[idx], 0);
    endtask

    initial begin
        int fr, nr, sk, ns, bl, ol, nrv, rvs, ba;
        logic [23:0] bits;

        vecs[0] = '{1'b0, 13'h0014, 8'hA5, 8'h00, 24'h0014A5, 200, 0, 8'h00};
        vecs[1] = '{1'b1, 13'h0001, 8'h00, 8'h88, 24'h800100, 132, 1, 8'h88};
        vecs[2] = '{1'b0, 13'h1FFF, 8'h3C, 8'h00, 24'h1FFF3C, 200, 0, 8'h88};
        vecs[3] = '{1'b1, 13'h00AB, 8'h00, 8'h5A, 24'h80AB00, 132, 1, 8'h5A};
        vecs[4] = '{1'b0, 13'h0000, 8'hFF, 8'h00, 24'h0000FF, 200, 0, 8'h5A};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy_v[1], 0);
        chk("rst_sclk", sclk_v[1], 0);
        chk("rst_sdio", sdio_v[1], 0);
        chk("rst_oe", oe_v[1], 0);
        chk("rst_stop", stop_v[1], 0);
        chk("rst_rv", rv_v[1], 0);
        chk("rst_rdata", rdata4, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Asynchronous reset in the middle of SHIFT.
        rw_r = 1'b0; addr_r = 13'h0014; wdata_r = 8'hA5; start_v[1] = 1'b1;
        @(posedge clk); #1;
        start_v[1] = 1'b0;
        repeat (90) @(posedge clk);
        #1;
        chk("arst_pre_sclk", sclk_v[1], 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_sclk", sclk_v[1], 0);
        chk("arst_oe", oe_v[1], 0);
        chk("arst_busy", busy_v[1], 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ns = 0;
        for (int k = 0; k < 150; k++) begin
            @(posedge clk); #1;
            if (stop_v[1] || busy_v[1]) ns++;
        end
        chk("arst_no_stop", ns, 0);

        // Table-driven frames.
        for (int i = 0; i < 5; i++) begin
            run_frame(vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].rbyte, 1'b0, 1'b0,
                      fr, nr, bits, sk, ns, bl, ol, nrv, rvs, ba);
            chk($sformatf("v%0d_first_rise", i), fr, 8);
            chk($sformatf("v%0d_rises", i), nr, 24);
            if (vecs[i].rw)
                chk($sformatf("v%0d_instr_bits", i), {16'h0, bits[23:8]}, {16'h0, vecs[i].exp_bits[23:8]});
            else
                chk($sformatf("v%0d_frame_bits", i), {8'h0, bits}, {8'h0, vecs[i].exp_bits});
            chk($sformatf("v%0d_stop_time", i), sk, 200);
            chk($sformatf("v%0d_stop_count", i), ns, 1);
            chk($sformatf("v%0d_busy_low", i), bl, 201);
            chk($sformatf("v%0d_oe_low", i), ol, vecs[i].exp_oe_low);
            chk($sformatf("v%0d_rv_count", i), nrv, vecs[i].exp_rv);
            chk($sformatf("v%0d_rv_at_stop", i), rvs, vecs[i].exp_rv);
            chk($sformatf("v%0d_rdata", i), rdata4, vecs[i].exp_rdata);
            chk($sformatf("v%0d_busy_after", i), ba, 0);
            repeat (3) @(negedge clk);
        end

        // Starts while busy (mid-frame and on the stop cycle) are ignored.
        run_frame(1'b0, 13'h0014, 8'hA5, 8'h00, 1'b1, 1'b0, fr, nr, bits, sk, ns, bl, ol, nrv, rvs, ba);
        chk("ign_bits", {8'h0, bits}, 32'h0014A5);
        chk("ign_rises", nr, 24);
        chk("ign_stop_time", sk, 200);
        chk("ign_stop_count", ns, 1);
        chk("ign_busy_after", ba, 0);
        repeat (3) @(negedge clk);

        // A start in the cycle after stop is accepted.
        run_frame(1'b0, 13'h0014, 8'hA5, 8'h00, 1'b0, 1'b1, fr, nr, bits, sk, ns, bl, ol, nrv, rvs, ba);
        chk("chain_stop_time", sk, 200);
        chk("chain_busy_again", ba, 1);
        sk = -1;
        for (int j = 210; j <= 450; j++) begin
            @(posedge clk); #1;
            if (stop_v[1] && sk < 0) sk = j;
        end
        chk("chain_second_stop", sk, 402);
        chk("chain_idle", busy_v[1], 0);

        // Divider extremes.
        run_div(0, 2);
        run_div(2, 255);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ad9648_spi_shifter.md
Name: ad9648_spi_shifter

Overview:
- Serial engine of the AD9648 3-wire SPI configuration path, directly downstream of the chip-select stage.
- Consumes the start pulse forwarded with CSB assertion, generates SCLK, and shifts a 24-bit frame on SDIO: R/W bit, W1:W0 = 00, 13-bit address, 8-bit data.
- For reads, releases SDIO after the instruction phase and captures the readback byte.
- Returns a one-cycle stop pulse that the chip-select stage uses to deassert CSB.

Parameters:
- CLK_DIV, 4, clk_i cycles per SCLK half-period; legal range 2..255.
- ADDR_W, 13, register address width; fixed by the AD9648 instruction format.
- DATA_W, 8, data byte width.

Ports:
- clk_i  in  1  system clock
- rst_clk_ni  in  1  reset; asynchronous assert, active-low
- start_gen_i  in  1  one-cycle frame start, coincident with the start that drives CSB low
- rw_i  in  1  1 = read, 0 = write; sampled with start_gen_i
- addr_i  in  ADDR_W  register address; sampled with start_gen_i
- wdata_i  in  DATA_W  write byte; sampled with start_gen_i, ignored on reads
- busy_o  out  1  frame in progress
- sclk_o  out  1  SPI clock, idles low
- sdio_o  out  1  serial data out
- sdio_oe_o  out  1  SDIO output enable for the IOBUF
- sdio_i  in  1  serial data in
- stop_gen_o  out  1  one-cycle end-of-frame pulse to the chip-select stage
- rdata_o  out  DATA_W  last readback byte; holds until the next read completes
- rdata_valid_o  out  1  one-cycle pulse, coincident with stop_gen_o on reads only

Behaviour:
Reset:
- Async reset, active-low. All outputs 0; state IDLE; shift register, counters and rdata_o cleared.
- Reset mid-frame aborts immediately: sclk_o low, sdio_oe_o low, no stop pulse. The integrator resets the chip-select stage together with this block.

State machine: IDLE -> LEAD -> SHIFT -> TRAIL -> IDLE.

IDLE:
- start_gen_i high at clock edge T0 loads shift register {rw_i, 2'b00, addr_i, wdata_i}.
- From T0: busy_o=1, sdio_oe_o=1, sdio_o=bit23 (= rw_i). Go to LEAD.
- start_gen_i outside IDLE is ignored, including during the stop_gen_o cycle.

LEAD:
- CLK_DIV cycles with sclk_o low (CSB-to-SCLK setup); then SHIFT.

SHIFT:
- Half-period counter 0..CLK_DIV-1; sclk_o toggles at terminal count. 48 toggles total.
- Rising edge n (n = 1..24) occurs at T0 + 2*CLK_DIV + 2*(n-1)*CLK_DIV.
- Falling edges: sdio_o advances to the next bit on the same clk_i edge that drives sclk_o low. The ADC samples on SCLK rising, so data is stable for one half-period.
- Read frames:
  - sdio_oe_o deasserts on the falling edge following rising edge 16.
  - sdio_i is sampled on the clk_i edge that drives sclk_o high, for rising edges 17..24, MSB first, into the rdata shift register.
- Write frames: sdio_oe_o stays high through the whole frame.
- After the 24th falling edge (T0 + 49*CLK_DIV), sclk_o stays low; go to TRAIL.

TRAIL:
- CLK_DIV cycles with sclk_o low.
- At T0 + 50*CLK_DIV: stop_gen_o=1 for one cycle; sdio_oe_o=0; on reads, rdata_o is updated and rdata_valid_o pulses in the same cycle.
- Next cycle: IDLE, busy_o=0. A new start is accepted from that cycle on.

Counters:
- Bit counter is 5 bits and counts rising edges.
- Half-period counter is 8 bits, so CLK_DIV up to 255 must not overflow.

Test Plan:
- Write: CLK_DIV=4, rw=0, addr=0x014, wdata=0xA5, start at T0 -> 24 SCLK pulses; first rise at T0+8; SDIO bits sampled at rises read 0x0014A5; sdio_oe high throughout; stop_gen_o pulse at T0+200; busy low at T0+201; no rdata_valid_o.
- Read: rw=1, addr=0x001, bench drives 0x88 MSB-first on SDIO after rise 16 -> sdio_oe_o low from T0+132; rdata_o=0x88 with rdata_valid_o coincident with stop_gen_o.
- Ignore start while busy: pulse start_gen_i at T0+50 and again on the stop_gen_o cycle -> no effect; exactly one stop pulse; frame unchanged. Start at stop+1 is accepted.
- Async reset asserted mid-SHIFT (T0+90) -> sclk_o, sdio_oe_o, busy_o go 0 without a clock edge; no stop_gen_o; a following clean write completes normally.
- CLK_DIV=2 and CLK_DIV=255 writes -> stop_gen_o at T0+100 and T0+12750 respectively; SCLK high and low times equal CLK_DIV cycles.
